// File: rtl/regfile_rdseq.sv
// Eight-entry register bank with a two-operand read sequencer driving an external mux8.
// Optional build macro REGFILE_RDSEQ_FWD_EN: operand latches take same-cycle write data.
module regfile_rdseq #(
    parameter int            DW      = 16,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    ra,
    input  logic [2:0]    rb,
    input  logic          wr_en,
    input  logic [2:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [DW-1:0] mux_op,
    output logic [DW-1:0] r0,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2,
    output logic [DW-1:0] r3,
    output logic [DW-1:0] r4,
    output logic [DW-1:0] r5,
    output logic [DW-1:0] r6,
    output logic [DW-1:0] r7,
    output logic [2:0]    sel,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          busy,
    output logic          done
);

    // state | meaning
    // IDLE  | waiting for start; sel holds its last value
    // RD_A  | sel points at operand A; a_out captures at the edge
    // RD_B  | sel points at operand B; b_out captures at the edge
    // DONE  | done pulse cycle; start ignored
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    rb_q;
    logic [DW-1:0] regs [8];
    logic [DW-1:0] operand;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

`ifdef REGFILE_RDSEQ_FWD_EN
    // sel names the register being read, so a matching write is forwarded
    assign operand = (wr_en && (wr_addr == sel)) ? wr_data : mux_op;
`else
    assign operand = mux_op;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            rb_q  <= '0;
            a_out <= '0;
            b_out <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rb_q  <= rb;
                        sel   <= ra;
                        busy  <= 1'b1;
                        state <= RD_A;
                    end
                end
                RD_A: begin
                    a_out <= operand;
                    sel   <= rb_q;
                    state <= RD_B;
                end
                RD_B: begin
                    b_out <= operand;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
